// File: rtl/vend_controller.sv
// Coin-operated dispenser sequencer: edge-detects coins, accumulates credit in nickels,
// handshakes the dispense request and pays change/refunds as spaced nickel pulses.
module vend_controller #(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 15,
  parameter int CREDIT_W   = 5,
  parameter int TIMEOUT    = 1000,
  parameter int CHANGE_GAP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic                cancel,
  input  logic                dispense_ack,
  output logic                open,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // state    | meaning
  // IDLE     | no credit, waiting for the first coin
  // COLLECT  | credit below price, accepting coins, timeout running
  // DISPENSE | open raised, waiting for dispense_ack
  // CHANGE   | paying remaining credit back one nickel per pulse
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = $clog2(CHANGE_GAP + 1);

  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_C      = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] VAL_NICKEL = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] VAL_DIME   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] VAL_QUART  = CREDIT_W'(5);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]    GAP_LOAD   = GAP_W'(CHANGE_GAP - 1);

  state_t                state, state_next;
  logic                  nickel_hist, dime_hist, quarter_hist;
  logic                  ev_nickel, ev_dime, ev_quarter;
  logic                  any_event, multi_event, fits;
  logic [CREDIT_W-1:0]   coin_val, credit_sum, credit_next;
  logic                  open_next, change_next, reject_next, busy_next;
  logic [TO_W-1:0]       to_cnt, to_next;
  logic [GAP_W-1:0]      gap_cnt, gap_next;

  assign ev_nickel   = nickel_in  & ~nickel_hist;
  assign ev_dime     = dime_in    & ~dime_hist;
  assign ev_quarter  = quarter_in & ~quarter_hist;
  assign any_event   = ev_nickel | ev_dime | ev_quarter;
  assign multi_event = (ev_quarter & ev_dime) | (ev_quarter & ev_nickel) | (ev_dime & ev_nickel);

  always_comb begin
    coin_val = '0;
    if (ev_quarter)     coin_val = VAL_QUART;
    else if (ev_dime)   coin_val = VAL_DIME;
    else if (ev_nickel) coin_val = VAL_NICKEL;
  end

  assign credit_sum = credit + coin_val;
  assign fits       = (credit_sum <= MAX_C);

  always_comb begin
    state_next  = state;
    credit_next = credit;
    reject_next = 1'b0;
    change_next = 1'b0;
    to_next     = to_cnt;
    gap_next    = gap_cnt;

    case (state)
      IDLE: begin
        if (any_event) begin
          if (fits) begin
            reject_next = multi_event;
            credit_next = credit_sum;
            to_next     = '0;
            state_next  = (credit_sum >= PRICE_C) ? DISPENSE : COLLECT;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          reject_next = any_event;
          to_next     = '0;
          state_next  = CHANGE;
        end else if (any_event && fits) begin
          reject_next = multi_event;
          credit_next = credit_sum;
          to_next     = '0;
          if (credit_sum >= PRICE_C) state_next = DISPENSE;
        end else begin
          // an over-limit coin does not count as activity for the timeout
          reject_next = any_event;
          if (to_cnt == TO_LAST) begin
            to_next    = '0;
            state_next = CHANGE;
          end else begin
            to_next = to_cnt + 1'b1;
          end
        end
      end
      DISPENSE: begin
        reject_next = any_event;
        if (dispense_ack) begin
          credit_next = credit - PRICE_C;
          state_next  = (credit == PRICE_C) ? IDLE : CHANGE;
        end
      end
      CHANGE: begin
        reject_next = any_event;
        if (change_nickel) begin
          credit_next = credit - 1'b1;
          gap_next    = gap_cnt - 1'b1;
          if (credit == VAL_NICKEL) state_next = IDLE;
        end else if (gap_cnt == '0) begin
          change_next = 1'b1;
          gap_next    = GAP_LOAD;
        end else begin
          gap_next = gap_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Entering CHANGE launches the first pulse so it appears in the first cycle there.
    if (state_next == CHANGE && state != CHANGE) begin
      change_next = 1'b1;
      gap_next    = GAP_LOAD;
    end

    open_next = (state_next == DISPENSE);
    busy_next = (state_next == DISPENSE) || (state_next == CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      credit        <= '0;
      open          <= 1'b0;
      change_nickel <= 1'b0;
      coin_reject   <= 1'b0;
      busy          <= 1'b0;
      nickel_hist   <= 1'b0;
      dime_hist     <= 1'b0;
      quarter_hist  <= 1'b0;
      to_cnt        <= '0;
      gap_cnt       <= '0;
    end else begin
      state         <= state_next;
      credit        <= credit_next;
      open          <= open_next;
      change_nickel <= change_next;
      coin_reject   <= reject_next;
      busy          <= busy_next;
      nickel_hist   <= nickel_in;
      dime_hist     <= dime_in;
      quarter_hist  <= quarter_in;
      to_cnt        <= to_next;
      gap_cnt       <= gap_next;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed vector table, hand-written corner sequences,
// and randomized coin/cancel/ack traffic checked against a behavioural model.
module tb_vend_controller;

  localparam int PRICE      = 3;
  localparam int MAX_CREDIT = 15;
  localparam int CREDIT_W   = 5;
  localparam int TIMEOUT    = 1000;
  localparam int CHANGE_GAP = 4;

  logic clk = 1'b0;
  logic reset, nickel_in, dime_in, quarter_in, cancel, dispense_ack;
  logic open, change_nickel, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;

  vend_controller #(
    .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W),
    .TIMEOUT(TIMEOUT), .CHANGE_GAP(CHANGE_GAP)
  ) dut (
    .clk(clk), .reset(reset), .nickel_in(nickel_in), .dime_in(dime_in),
    .quarter_in(quarter_in), .cancel(cancel), .dispense_ack(dispense_ack),
    .open(open), .change_nickel(change_nickel), .coin_reject(coin_reject),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic n, d, q, c, a;
    int   cr;
    logic op, cn, rej, bz;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int count, input logic n, d, q, c, a,
                     input int cr, input logic op, cn, rej, bz);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.c = c; v.a = a;
    v.cr = cr; v.op = op; v.cn = cn; v.rej = rej; v.bz = bz;
    for (int i = 0; i < count; i++) vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic n, d, q, c, a);
    nickel_in = n; dime_in = d; quarter_in = q; cancel = c; dispense_ack = a;
  endtask

  task automatic check_out(input string tag, input int cr, input logic op, cn, rej, bz);
    check({tag, ".credit"}, int'(credit), cr);
    check({tag, ".open"}, int'(open), int'(op));
    check({tag, ".change_nickel"}, int'(change_nickel), int'(cn));
    check({tag, ".coin_reject"}, int'(coin_reject), int'(rej));
    check({tag, ".busy"}, int'(busy), int'(bz));
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Behavioural reference: mode 0 idle, 1 collecting, 2 awaiting ack, 3 refunding.
  int m_mode, m_credit, m_idle, m_age;
  logic m_hn, m_hd, m_hq, m_rej;

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_idle = 0; m_age = 0;
    m_hn = 0; m_hd = 0; m_hq = 0; m_rej = 0;
  endtask

  task automatic model_step(input logic n, d, q, c, a);
    int en, ed, eq, cnt, val;
    en = (n && !m_hn) ? 1 : 0;
    ed = (d && !m_hd) ? 1 : 0;
    eq = (q && !m_hq) ? 1 : 0;
    m_hn = n; m_hd = d; m_hq = q;
    cnt = en + ed + eq;
    val = (eq != 0) ? 5 : (ed != 0) ? 2 : (en != 0) ? 1 : 0;
    m_rej = 0;
    case (m_mode)
      0: if (cnt > 0) begin
           if (m_credit + val <= MAX_CREDIT) begin
             m_rej = (cnt > 1);
             m_credit += val;
             m_idle = 0;
             m_mode = (m_credit >= PRICE) ? 2 : 1;
           end else m_rej = 1;
         end
      1: if (c) begin
           m_rej = (cnt > 0); m_mode = 3; m_age = 0;
         end else if (cnt > 0 && m_credit + val <= MAX_CREDIT) begin
           m_rej = (cnt > 1); m_credit += val; m_idle = 0;
           if (m_credit >= PRICE) m_mode = 2;
         end else begin
           m_rej = (cnt > 0);
           m_idle++;
           if (m_idle >= TIMEOUT) begin m_mode = 3; m_age = 0; end
         end
      2: begin
           m_rej = (cnt > 0);
           if (a) begin
             m_credit -= PRICE;
             if (m_credit > 0) begin m_mode = 3; m_age = 0; end
             else m_mode = 0;
           end
         end
      default: begin
           m_rej = (cnt > 0);
           if (m_age % CHANGE_GAP == 0) begin
             m_credit--;
             if (m_credit == 0) m_mode = 0;
           end
           m_age++;
         end
    endcase
  endtask

  function automatic int model_packed();
    int op, cn, bz;
    op = (m_mode == 2) ? 1 : 0;
    bz = (m_mode >= 2) ? 1 : 0;
    cn = (m_mode == 3 && m_age % CHANGE_GAP == 0) ? 1 : 0;
    return op * 256 + cn * 128 + int'(m_rej) * 64 + bz * 32 + m_credit;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, pulses, last;
    logic n, d, q, c, a;

    do_reset();
    check_out("reset", 0, 0, 0, 0, 0);

    // nickel x3 then ack with exact price
    add(1, 1,0,0,0,0, 1, 0,0,0,0);
    add(4, 0,0,0,0,0, 1, 0,0,0,0);
    add(1, 1,0,0,0,0, 2, 0,0,0,0);
    add(4, 0,0,0,0,0, 2, 0,0,0,0);
    add(1, 1,0,0,0,0, 3, 1,0,0,1);
    add(3, 0,0,0,0,0, 3, 1,0,0,1);
    add(1, 0,0,0,0,1, 0, 0,0,0,0);
    add(1, 0,0,0,0,0, 0, 0,0,0,0);
    // nickel+dime together, then dime during DISPENSE
    add(1, 1,1,0,0,0, 2, 0,0,1,0);
    add(1, 0,0,0,0,0, 2, 0,0,0,0);
    add(1, 1,0,0,0,0, 3, 1,0,0,1);
    add(1, 0,1,0,0,0, 3, 1,0,1,1);
    add(1, 0,0,0,0,0, 3, 1,0,0,1);
    add(1, 0,0,0,0,1, 0, 0,0,0,0);
    add(1, 0,0,0,0,0, 0, 0,0,0,0);
    // dime then cancel: two refund pulses CHANGE_GAP apart
    add(1, 0,1,0,0,0, 2, 0,0,0,0);
    add(1, 0,0,0,1,0, 2, 0,1,0,1);
    add(3, 0,0,0,0,0, 1, 0,0,0,1);
    add(1, 0,0,0,0,0, 1, 0,1,0,1);
    add(1, 0,0,0,0,0, 0, 0,0,0,0);

    foreach (vecs[i]) begin
      set_in(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].c, vecs[i].a);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].cr, vecs[i].op, vecs[i].cn, vecs[i].rej, vecs[i].bz);
    end

    // quarter: dispense, then 2 nickels change spaced CHANGE_GAP apart
    set_in(0, 0, 1, 0, 0); tick();
    check_out("quarter_in", 5, 1, 0, 0, 1);
    set_in(0, 0, 0, 0, 0); tick(); tick();
    check("quarter_hold.open", int'(open), 1);
    set_in(0, 0, 0, 0, 1); tick();
    check_out("quarter_ack", 2, 0, 1, 0, 1);
    set_in(0, 0, 0, 0, 0);
    pulses = 1; last = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (change_nickel) begin
        check("change_spacing", j - last, CHANGE_GAP);
        pulses++; last = j;
      end
      if (j == CHANGE_GAP) check("change_busy_before_last_edge", int'(busy), 1);
      if (j == CHANGE_GAP + 1) begin
        check("change_busy_fall", int'(busy), 0);
        check("change_credit_zero", int'(credit), 0);
      end
    end
    check("change_pulse_count", pulses, 2);

    // single nickel left alone: refund exactly TIMEOUT cycles after the credit edge
    set_in(1, 0, 0, 0, 0); tick();
    check_out("timeout_credit", 1, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0);
    k = 0;
    while (!busy && k < TIMEOUT + 100) begin tick(); k++; end
    check("timeout_latency", k, TIMEOUT);
    check_out("timeout_refund", 1, 0, 1, 0, 1);
    tick();
    check_out("timeout_done", 0, 0, 0, 0, 0);

    // asynchronous reset in the middle of a 3-nickel change sequence
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 1, 0, 0); tick();
    check("midreset_setup.credit", int'(credit), 6);
    set_in(0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1); tick();
    check_out("midreset_change", 3, 0, 1, 0, 1);
    set_in(0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check_out("midreset_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    pulses = 0;
    k = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      pulses += int'(change_nickel) + int'(coin_reject) + int'(open);
      k += int'(busy) + int'(credit);
    end
    check("postreset_quiet_pulses", pulses, 0);
    check("postreset_quiet_state", k, 0);

    // randomized traffic against the reference model; second segment is quiet to hit timeouts
    do_reset();
    model_reset();
    n = 0; d = 0; q = 0; c = 0; a = 0;
    for (int seg = 0; seg < 3; seg++) begin
      int len, coin_rate;
      len       = (seg == 1) ? 1200 : 1500;
      coin_rate = (seg == 1) ? 0 : 6;
      for (int j = 0; j < len; j++) begin
        if (coin_rate != 0) begin
          if ($urandom_range(coin_rate - 1) == 0) n = ~n;
          if ($urandom_range(coin_rate - 1) == 0) d = ~d;
          if ($urandom_range(coin_rate * 2 - 1) == 0) q = ~q;
          c = ($urandom_range(24) == 0);
        end else begin
          c = 1'b0;
        end
        a = ($urandom_range(3) == 0);
        set_in(n, d, q, c, a);
        model_step(n, d, q, c, a);
        tick();
        check($sformatf("rand_s%0d_c%0d", seg, j),
              int'({23'b0, open, change_nickel, coin_reject, busy, credit}),
              model_packed());
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
